// File: rtl/ps2_pkg.sv
// ps2_pkg -- constants and helpers shared by the PS/2 keyboard receiver.
//   BREAK_CODE      : scan-code prefix that announces a key release
//   FRAME_BITS      : start + 8 data + parity + stop
//   DEF_FIFO_DEPTH  : default scan-code FIFO depth
//   DEF_TIMEOUT_CYC : default idle limit that aborts a partial frame
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE      = 8'hF0;
  localparam int         FRAME_BITS      = 11;
  localparam int         DEF_FIFO_DEPTH  = 8;
  localparam int         DEF_TIMEOUT_CYC = 4096;

  // shift holds {parity, data[7:0], start}; stop is the bit arriving now.
  // Data plus parity must carry an odd number of ones.
  function automatic logic frame_ok(input logic [9:0] shift, input logic stop);
    return (shift[0] == 1'b0) && stop && (^shift[9:1]);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with first-word-fall-through head.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push, pop  : write / read requests; pop is ignored when empty, and a push
//                while full is accepted only if a pop happens in the same cycle
//   wr_data    : byte to write
//   head       : current head entry (valid while !empty)
//   full, empty: occupancy flags
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop, w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; empty pointers make stale contents unobservable
  // and leaving reset off lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx -- PS/2 keyboard receiver with scan-code FIFO and key tracking.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   ps2_clk/data : raw PS/2 lines, asynchronous to clk
//   rd_en        : pop the FIFO head
//   scan_code    : FIFO head byte (valid while code_valid)
//   code_valid   : FIFO non-empty
//   overflow     : sticky, an accepted frame was dropped on a full FIFO
//   key_pressed  : a make code is held with no matching break yet
//   last_key     : most recent make code
//   key_count    : distinct key presses, wraps at 256
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       overflow,
  output logic       key_pressed,
  output logic [7:0] last_key,
  output logic [7:0] key_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    r_clk_sync, r_dat_sync;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_overflow, r_break, r_key_pressed;
  logic [7:0]    r_last_key, r_key_count;

  logic          w_fall, w_bit, w_last, w_accept;
  logic [7:0]    w_byte, w_head;
  logic          w_full, w_empty, w_pop;

  // NOTE: every clocked block uses non-blocking assignments so each flop
  // samples the value its neighbour held before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 3'b111;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[1:0], ps2_data};
    end
  end

  assign w_fall   = r_clk_sync[2] && !r_clk_sync[1];
  assign w_bit    = r_dat_sync[2];
  // The 11th edge carries the stop bit; the frame is judged in that cycle.
  assign w_last   = w_fall && (r_bit_cnt == 4'(FRAME_BITS - 1));
  assign w_accept = w_last && frame_ok(r_shift, w_bit);
  assign w_byte   = r_shift[8:1];
  assign w_pop    = rd_en && !w_empty;

  // Frame assembly with inactivity timeout on partial frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
      if (w_last) begin
        r_bit_cnt <= '0;
      end else begin
        r_shift   <= {w_bit, r_shift[9:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end else if (r_bit_cnt != 4'd0) begin
      if (r_to_cnt == TW'(TIMEOUT_CYC)) begin
        r_bit_cnt <= '0;
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Key tracking sees every accepted frame, even ones the FIFO drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow    <= 1'b0;
      r_break       <= 1'b0;
      r_key_pressed <= 1'b0;
      r_last_key    <= '0;
      r_key_count   <= '0;
    end else if (w_accept) begin
      if (w_full && !w_pop) r_overflow <= 1'b1;
      if (w_byte == BREAK_CODE) begin
        r_break <= 1'b1;
      end else if (r_break) begin
        r_break       <= 1'b0;
        r_key_pressed <= 1'b0;
      end else begin
        r_last_key <= w_byte;
        if (!r_key_pressed) begin
          r_key_pressed <= 1'b1;
          r_key_count   <= r_key_count + 8'd1;
        end
      end
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (w_accept),
    .pop     (rd_en),
    .wr_data (w_byte),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign scan_code   = w_head;
  assign code_valid  = !w_empty;
  assign overflow    = r_overflow;
  assign key_pressed = r_key_pressed;
  assign last_key    = r_last_key;
  assign key_count   = r_key_count;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx -- scoreboard bench for ps2_kbd_rx.
// clk = 1 MHz, PS/2 clock = 10 kHz (100 clk cycles per bit), aligned to clk.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TO    = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] scan_code, last_key, key_count;
  logic       code_valid, overflow, key_pressed;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic       exp_ovf;

  always #500 clk = ~clk;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd_en       (rd_en),
    .scan_code   (scan_code),
    .code_valid  (code_valid),
    .overflow    (overflow),
    .key_pressed (key_pressed),
    .last_key    (last_key),
    .key_count   (key_count)
  );

  initial begin
    #(64'd200_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic do_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    exp_ovf = 1'b0;
  endtask

  // Drives nbits of a frame. With pop set, rd_en is raised for the cycle in
  // which the 11th edge is evaluated (two clk edges through the synchronizer).
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (25) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop && i == 10) begin
        repeat (2) @(negedge clk);
        n_checks++;
        if (scan_code !== sb[0])
          $display("FAIL pop_during_push_head: got %h expected %h", scan_code, sb[0]);
        if (scan_code !== sb[0]) n_fail++;
        void'(sb.pop_front());
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (47) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (25) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  // Sends a good frame and records it in the scoreboard model.
  task automatic send_byte(input logic [7:0] b, input bit pop);
    send_bits(make_frame(b), 11, pop);
    if (sb.size() < DEPTH) sb.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!code_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (code_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: got %b expected 1 (timeout)", name, code_valid);
    end
  endtask

  // Pops everything the DUT holds and compares it against the scoreboard.
  task automatic drain(input string name, input int exp_n);
    int got = 0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      @(negedge clk);
      if (!code_valid) break;
      got++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s_extra: got %h expected no entry", name, scan_code);
      end else begin
        if (scan_code !== sb[0]) begin
          n_fail++;
          $display("FAIL %s_data[%0d]: got %h expected %h", name, k, scan_code, sb[0]);
        end
        void'(sb.pop_front());
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    n_checks++;
    if (got != exp_n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d expected %0d", name, got, exp_n);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: got %0d left expected 0", name, sb.size());
    end
  endtask

  task automatic check_keys(input string name, input logic kp, input logic [7:0] lk,
                            input logic [7:0] kc);
    n_checks++;
    if (key_pressed !== kp) begin
      n_fail++;
      $display("FAIL %s_key_pressed: got %b expected %b", name, key_pressed, kp);
    end
    n_checks++;
    if (last_key !== lk) begin
      n_fail++;
      $display("FAIL %s_last_key: got %h expected %h", name, last_key, lk);
    end
    n_checks++;
    if (key_count !== kc) begin
      n_fail++;
      $display("FAIL %s_key_count: got %h expected %h", name, key_count, kc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (code_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b ovf=%b expected 0 0", code_valid, overflow);
    end
    check_keys("reset", 1'b0, 8'h00, 8'h00);
    // Load some state, then confirm reset clears it without a clock edge.
    send_byte(8'h1C, 1'b0);
    #100;
    rst = 1'b0;
    #100;
    n_checks++;
    if (code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_valid: got %b expected 0", code_valid);
    end
    check_keys("async_reset", 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_single();
    do_reset();
    send_byte(8'h1C, 1'b0);
    wait_valid("single");
    check_keys("single", 1'b1, 8'h1C, 8'h01);
    drain("single", 1);
  endtask

  task automatic test_make_break();
    do_reset();
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_keys("typematic", 1'b1, 8'h1C, 8'h01);
    send_byte(8'hF0, 1'b0);
    check_keys("break_prefix", 1'b1, 8'h1C, 8'h01);
    send_byte(8'h1C, 1'b0);
    check_keys("release", 1'b0, 8'h1C, 8'h01);
    drain("make_break", 4);
  endtask

  task automatic test_bad_frames();
    logic [10:0] f;
    do_reset();
    f = make_frame(8'h1C) ^ 11'h200;  // wrong parity
    send_bits(f, 11, 1'b0);
    f = make_frame(8'h2A) ^ 11'h400;  // stop bit low
    send_bits(f, 11, 1'b0);
    f = make_frame(8'h33) ^ 11'h001;  // start bit high
    send_bits(f, 11, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_frames_valid: got %b expected 0", code_valid);
    end
    check_keys("bad_frames", 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0);
    n_checks++;
    if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got %b expected 1", overflow);
    end
    check_keys("overflow", 1'b1, 8'h18, 8'h01);
    send_byte(8'h19, 1'b1);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b expected 1", overflow);
    end
    check_keys("full_pop_push", 1'b1, 8'h19, 8'h01);
    drain("overflow", DEPTH);
  endtask

  task automatic test_timeout();
    do_reset();
    send_bits(make_frame(8'hAA), 5, 1'b0);
    repeat (TO + 100) @(negedge clk);
    send_byte(8'h32, 1'b0);
    wait_valid("timeout");
    drain("timeout", 1);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_bits(make_frame(8'h5B), 6, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h1C, 1'b0);
    wait_valid("midframe");
    drain("midframe", 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_make_break();
    test_bad_frames();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scan-code FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, number of clk cycles of ps2_clk inactivity that aborts a partial frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port rd_en  input  1  consumer pop request for the FIFO head.
REQ-008 SHALL have port scan_code  output  8  FIFO head byte.
REQ-009 SHALL have port code_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky flag: an accepted frame was dropped because the FIFO was full.
REQ-011 SHALL have port key_pressed  output  1  a make code is held (no matching break yet).
REQ-012 SHALL have port last_key  output  8  most recent make code, for the hex display stage.
REQ-013 SHALL have port key_count  output  8  number of distinct key presses, wraps 255->0.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through 3-flop synchronizers each; a falling edge is detected when flop 3 = 1 and flop 2 = 0.
REQ-015 SHALL, on each detected falling edge, shift synchronized ps2_data into a 10-bit shift register LSB-first and increment a 4-bit bit counter.
REQ-016 SHALL treat the bit received on falling edge 11 (bit counter = 10) as the stop bit and evaluate the frame in that same cycle.
REQ-017 SHALL accept a frame only if start bit = 0, stop bit = 1, and the 8 data bits plus parity bit contain an odd number of ones; otherwise discard it silently.
REQ-018 SHALL clear the bit counter to 0 after every evaluated frame, accepted or not.
REQ-019 SHALL count clk cycles since the last falling edge while the bit counter is nonzero, and clear the bit counter and timeout counter when the count reaches TIMEOUT_CYC.
REQ-020 SHALL push an accepted byte into the FIFO in the evaluation cycle, making code_valid = 1 on the following cycle (latency = 1 cycle after the 11th synchronized edge).
REQ-021 SHALL keep scan_code equal to the FIFO head whenever code_valid = 1; scan_code is don't-care when code_valid = 0.
REQ-022 SHALL pop the head on rd_en = 1 with code_valid = 1, and ignore rd_en when the FIFO is empty.
REQ-023 SHALL, on push with FIFO full and no pop in the same cycle, drop the new byte, keep the FIFO contents, and set overflow.
REQ-024 SHALL perform both push and pop in the same cycle when full with rd_en = 1, leaving occupancy unchanged and overflow unaffected.
REQ-025 SHALL keep overflow set until reset.
REQ-026 SHALL update key tracking on every accepted frame, including frames dropped by the FIFO.
REQ-027 SHALL, on byte 0xF0, set an internal break_pending flag and leave last_key unchanged.
REQ-028 SHALL, on a byte other than 0xF0 with break_pending = 1, clear key_pressed and break_pending.
REQ-029 SHALL, on a byte other than 0xF0 with break_pending = 0 and key_pressed = 0, load last_key, set key_pressed, and increment key_count.
REQ-030 SHALL, on a byte other than 0xF0 with break_pending = 0 and key_pressed = 1 (typematic repeat), reload last_key and leave key_count unchanged.

Reset
REQ-031 SHALL, with rst = 0, asynchronously clear: synchronizer flops to 1; and shift register, bit counter, timeout counter, FIFO pointers, overflow, break_pending, key_pressed, last_key, key_count, and code_valid to 0.
REQ-032 SHALL, on reset mid-frame, abandon the partial frame and leave no FIFO entry from it.

Structure
REQ-033 SHALL take the constants BREAK_CODE = 8'hF0, frame length 11, and default FIFO_DEPTH/TIMEOUT_CYC from a shared package ps2_pkg.
REQ-034 SHALL implement the FIFO as one sub-module sync_fifo (push, pop, full, empty, head data).

Verification
REQ-035 SHALL cover: frame 0x1C (parity 0) at 10 kHz PS/2 clock -> code_valid = 1, scan_code = 0x1C, last_key = 0x1C, key_pressed = 1, key_count = 1.
REQ-036 SHALL cover: 0x1C, 0x1C, 0xF0 (parity 1), 0x1C -> four FIFO entries, key_count = 1, key_pressed = 0 at end.
REQ-037 SHALL cover: frame 0x1C with parity 1 -> no push, code_valid stays 0, key_count = 0.
REQ-038 SHALL cover: 9 frames with no rd_en -> 8 entries kept in order, overflow = 1; then a pop with a concurrent push -> occupancy stays 8.
REQ-039 SHALL cover: 5 bits, idle 4096 cycles, then full frame 0x32 -> scan_code = 0x32.
REQ-040 SHALL cover: rst = 0 after bit 6 of a frame, release, send 0x1C -> exactly one entry, 0x1C.
